// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: instruction-type codes, branch funct3 encodings
// and the EX branch-control FSM state type.
package pipe_pkg;

  localparam logic [4:0] TYPE_NOP    = 5'd0;
  localparam logic [4:0] TYPE_BRANCH = 5'd4;
  localparam logic [4:0] TYPE_JAL    = 5'd5;
  localparam logic [4:0] TYPE_JALR   = 5'd6;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    IDLE   = 1'b0,
    SHADOW = 1'b1
  } state_e;

endpackage

// File: rtl/branch_cmp.sv
// Conditional-branch comparator: funct3 plus two operands to a taken bit.
// Unrecognised funct3 encodings resolve as not-taken.
module branch_cmp
  import pipe_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        taken_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  always_comb begin
    eq      = (a_i == b_i);
    lt_s    = ($signed(a_i) < $signed(b_i));
    lt_u    = (a_i < b_i);
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = !eq;
      F3_BLT:  taken_o = lt_s;
      F3_BGE:  taken_o = !lt_s;
      F3_BLTU: taken_o = lt_u;
      F3_BGEU: taken_o = !lt_u;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_branch_ctrl.sv
// EX-stage branch resolution: registered redirect to fetch, kill shadow that
// squashes wrong-path instructions, and saturating branch statistics.
module ex_branch_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned KILL_CYCLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      inst_in,
  input  logic [31:0]      operand_a_val,
  input  logic [31:0]      operand_b_val,
  input  logic [31:0]      immx_data,
  input  logic [4:0]       inst_type,
  output logic             branch_kill_flag,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             target_misaligned,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count,
  output state_e           fsm_state
);

  localparam logic [3:0]       SHADOW_INIT = 4'(KILL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [3:0]       shadow_cnt_q, shadow_cnt_d;
  logic             kill_q, kill_d;
  logic             redir_valid_q, redir_valid_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic             misal_q, misal_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic        is_branch, is_jal, is_jalr;
  logic        cmp_taken, taken;
  logic [31:0] pc_target, jalr_sum, target;
  logic        unused_inst_bits;

  assign unused_inst_bits = ^{inst_in[31:15], inst_in[11:0], jalr_sum[0]};

  branch_cmp u_branch_cmp (
    .funct3_i (inst_in[14:12]),
    .a_i      (operand_a_val),
    .b_i      (operand_b_val),
    .taken_o  (cmp_taken)
  );

  // Operand-dependent terms are ANDed with known type decodes, so a no-op
  // type keeps X operands from reaching taken.
  always_comb begin
    is_branch = (inst_type == TYPE_BRANCH);
    is_jal    = (inst_type == TYPE_JAL);
    is_jalr   = (inst_type == TYPE_JALR);
    pc_target = ex_pc + immx_data;
    jalr_sum  = operand_a_val + immx_data;
    target    = is_jalr ? {jalr_sum[31:1], 1'b0} : pc_target;
    taken     = is_jal | is_jalr | (is_branch & cmp_taken);
  end

  always_comb begin
    state_d       = state_q;
    shadow_cnt_d  = shadow_cnt_q;
    kill_d        = 1'b0;
    redir_valid_d = 1'b0;
    redir_pc_d    = redir_pc_q;
    misal_d       = 1'b0;
    branch_cnt_d  = branch_cnt_q;
    taken_cnt_d   = taken_cnt_q;
    case (state_q)
      IDLE: begin
        if (is_branch && !(&branch_cnt_q)) begin
          branch_cnt_d = branch_cnt_q + CNT_ONE;
        end
        if (taken) begin
          if (target[1:0] == 2'b00) begin
            state_d       = SHADOW;
            shadow_cnt_d  = SHADOW_INIT;
            kill_d        = 1'b1;
            redir_valid_d = 1'b1;
            redir_pc_d    = target;
            if (!(&taken_cnt_q)) begin
              taken_cnt_d = taken_cnt_q + CNT_ONE;
            end
          end else begin
            misal_d = 1'b1;
          end
        end
      end
      SHADOW: begin
        // Nothing from the EX inputs is consulted while the shadow runs.
        if (shadow_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          shadow_cnt_d = shadow_cnt_q - 4'd1;
          kill_d       = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shadow_cnt_q  <= 4'd0;
      kill_q        <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'd0;
      misal_q       <= 1'b0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      shadow_cnt_q  <= shadow_cnt_d;
      kill_q        <= kill_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      misal_q       <= misal_d;
      branch_cnt_q  <= branch_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign branch_kill_flag  = kill_q;
  assign redirect_valid    = redir_valid_q;
  assign redirect_pc       = redir_pc_q;
  assign target_misaligned = misal_q;
  assign branch_count      = branch_cnt_q;
  assign taken_count       = taken_cnt_q;
  assign fsm_state         = state_q;

endmodule

// File: tb/tb_ex_branch_ctrl.sv
// Bench for ex_branch_ctrl: vector table, hand sequences and random stimulus
// checked every cycle against a remaining-kill-cycles reference model.
module tb_ex_branch_ctrl;
  import pipe_pkg::*;

  localparam int KC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] ex_pc, inst_in, op_a, op_b, imm;
  logic [4:0]  inst_type;

  logic        kill, rv, mis;
  logic [31:0] rpc, bcnt, tcnt;
  state_e      st;

  logic        kill_s, rv_s, mis_s;
  logic [31:0] rpc_s;
  logic [2:0]  bcnt_s, tcnt_s;
  state_e      st_s;

  ex_branch_ctrl #(.KILL_CYCLES(KC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ex_pc(ex_pc), .inst_in(inst_in),
    .operand_a_val(op_a), .operand_b_val(op_b), .immx_data(imm),
    .inst_type(inst_type), .branch_kill_flag(kill), .redirect_valid(rv),
    .redirect_pc(rpc), .target_misaligned(mis), .branch_count(bcnt),
    .taken_count(tcnt), .fsm_state(st)
  );

  // Narrow-counter instance so saturation is reached in a few dozen cycles.
  ex_branch_ctrl #(.KILL_CYCLES(KC), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .ex_pc(ex_pc), .inst_in(inst_in),
    .operand_a_val(op_a), .operand_b_val(op_b), .immx_data(imm),
    .inst_type(inst_type), .branch_kill_flag(kill_s), .redirect_valid(rv_s),
    .redirect_pc(rpc_s), .target_misaligned(mis_s), .branch_count(bcnt_s),
    .taken_count(tcnt_s), .fsm_state(st_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: number of kill cycles still owed, plus plain counts.
  int          m_rem;
  logic        m_rv, m_mis;
  logic [31:0] m_pc;
  longint      m_bc, m_tc;

  typedef struct {
    logic [4:0]  t;
    logic [2:0]  f3;
    logic [31:0] a, b, pc, im;
    logic        e_rv;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic cond_true(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int signed sa = a;
    int signed sb = b;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    logic        tk;
    logic [31:0] tgt;
    m_rv  = 1'b0;
    m_mis = 1'b0;
    if (rst) begin
      m_rem = 0; m_pc = 0; m_bc = 0; m_tc = 0;
    end else if (m_rem > 0) begin
      m_rem--;
    end else begin
      tk  = 1'b0;
      tgt = ex_pc + imm;
      if (inst_type == 5'd4) begin
        m_bc++;
        tk = cond_true(inst_in[14:12], op_a, op_b);
      end else if (inst_type == 5'd5) begin
        tk = 1'b1;
      end else if (inst_type == 5'd6) begin
        tk  = 1'b1;
        tgt = (op_a + imm) & 32'hFFFF_FFFE;
      end
      if (tk) begin
        if (tgt % 4 == 0) begin
          m_rv = 1'b1; m_pc = tgt; m_rem = KC; m_tc++;
        end else begin
          m_mis = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("redirect_valid", {31'd0, rv}, {31'd0, m_rv});
    check("redirect_pc", rpc, m_pc);
    check("kill_flag", {31'd0, kill}, {31'd0, m_rem > 0});
    check("target_misaligned", {31'd0, mis}, {31'd0, m_mis});
    check("fsm_state", {31'd0, st}, (m_rem > 0) ? 32'd1 : 32'd0);
    check("branch_count", bcnt, m_bc[31:0]);
    check("taken_count", tcnt, m_tc[31:0]);
    check("sat_branch_count", {29'd0, bcnt_s}, (m_bc > 7) ? 32'd7 : m_bc[31:0]);
    check("sat_taken_count", {29'd0, tcnt_s}, (m_tc > 7) ? 32'd7 : m_tc[31:0]);
  endtask

  task automatic drive(input logic [4:0] t, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [31:0] im);
    inst_type = t;
    inst_in   = $urandom;
    inst_in[14:12] = f3;
    op_a = a; op_b = b; ex_pc = pc; imm = im;
  endtask

  task automatic drain();
    drive(TYPE_NOP, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    for (int k = 0; k < KC; k++) tick();
  endtask

  initial begin
    rst = 1'b1;
    m_rem = 0; m_pc = 0; m_bc = 0; m_tc = 0; m_rv = 0; m_mis = 0;
    drive(TYPE_NOP, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    check("reset_kill", {31'd0, kill}, 32'd0);
    check("reset_pc", rpc, 32'd0);

    vecs[0]  = '{TYPE_BRANCH, F3_BEQ,  32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120, 1'b0};
    vecs[1]  = '{TYPE_BRANCH, F3_BNE,  32'd5, 32'd5, 32'h100, 32'h20, 1'b0, 32'h0, 1'b0};
    vecs[2]  = '{TYPE_BRANCH, F3_BLT,  32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b1, 32'h240, 1'b0};
    vecs[3]  = '{TYPE_BRANCH, F3_BLTU, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h40, 1'b0, 32'h0, 1'b0};
    vecs[4]  = '{TYPE_BRANCH, F3_BGE,  32'd1, 32'hFFFFFFFF, 32'h300, 32'hFFFFFFF8, 1'b1, 32'h2F8, 1'b0};
    vecs[5]  = '{TYPE_BRANCH, F3_BGEU, 32'd1, 32'hFFFFFFFF, 32'h300, 32'hFFFFFFF8, 1'b0, 32'h0, 1'b0};
    vecs[6]  = '{TYPE_BRANCH, 3'b010,  32'd7, 32'd7, 32'h300, 32'h10, 1'b0, 32'h0, 1'b0};
    vecs[7]  = '{TYPE_JAL,    3'b000,  32'd0, 32'd0, 32'hFFFFFFF0, 32'h20, 1'b1, 32'h10, 1'b0};
    vecs[8]  = '{TYPE_JALR,   3'b000,  32'h101, 32'd0, 32'h40, 32'h100, 1'b1, 32'h200, 1'b0};
    vecs[9]  = '{TYPE_JALR,   3'b000,  32'h203, 32'd0, 32'h40, 32'h0, 1'b0, 32'h0, 1'b1};
    vecs[10] = '{TYPE_BRANCH, F3_BEQ,  32'd9, 32'd9, 32'h100, 32'h22, 1'b0, 32'h0, 1'b1};
    vecs[11] = '{5'd3,        F3_BEQ,  32'd9, 32'd9, 32'h100, 32'h20, 1'b0, 32'h0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].t, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].pc, vecs[i].im);
      tick();
      check($sformatf("vec%0d_rv", i), {31'd0, rv}, {31'd0, vecs[i].e_rv});
      check($sformatf("vec%0d_mis", i), {31'd0, mis}, {31'd0, vecs[i].e_mis});
      check($sformatf("vec%0d_kill", i), {31'd0, kill}, {31'd0, vecs[i].e_rv});
      if (vecs[i].e_rv) check($sformatf("vec%0d_pc", i), rpc, vecs[i].e_pc);
      if (i == 0) begin
        check("beq_branch_count", bcnt, 32'd1);
        check("beq_taken_count", tcnt, 32'd1);
      end
      drain();
    end

    // JAL, then X-valued and taken-branch inputs in the shadow, then a taken BNE.
    drive(TYPE_JAL, 3'b000, 32'd0, 32'd0, 32'h1000, 32'h80);
    tick();
    check("jal_pc", rpc, 32'h1080);
    inst_type = 'x; inst_in = 'x; op_a = 'x; op_b = 'x; ex_pc = 'x; imm = 'x;
    tick();
    check("shadow_x_rv", {31'd0, rv}, 32'd0);
    drive(TYPE_BRANCH, F3_BEQ, 32'd3, 32'd3, 32'h500, 32'h40);
    tick();
    check("shadow_br_rv", {31'd0, rv}, 32'd0);
    check("shadow_end_kill", {31'd0, kill}, 32'd0);
    drive(TYPE_BRANCH, F3_BNE, 32'd3, 32'd4, 32'h600, 32'h10);
    tick();
    check("post_shadow_rv", {31'd0, rv}, 32'd1);
    check("post_shadow_pc", rpc, 32'h610);

    // Reset asserted for two cycles in the middle of a shadow.
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("midreset_kill", {31'd0, kill}, 32'd0);
    check("midreset_state", {31'd0, st}, 32'd0);
    check("midreset_bcnt", bcnt, 32'd0);
    check("midreset_tcnt", tcnt, 32'd0);
    drive(TYPE_NOP, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();

    // Ten redirects push the 3-bit counters past all-ones.
    for (int i = 0; i < 10; i++) begin
      drive(TYPE_BRANCH, F3_BEQ, 32'd1, 32'd1, 32'h40 * i, 32'h8);
      tick();
      drain();
    end
    check("sat_taken_final", {29'd0, tcnt_s}, 32'd7);
    check("sat_branch_final", {29'd0, bcnt_s}, 32'd7);
    check("wide_taken_final", tcnt, 32'd10);

    for (int i = 0; i < 400; i++) begin
      int          sel;
      logic [31:0] a, b, im;
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
      im  = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      if (sel == 5 && $urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      case (sel)
        4:       drive(TYPE_JAL, 3'($urandom), a, b, $urandom & 32'hFFFF_FFFC, im);
        5:       drive(TYPE_JALR, 3'($urandom), a, b, $urandom & 32'hFFFF_FFFC, im);
        6:       drive(TYPE_NOP, 3'($urandom), a, b, $urandom, im);
        7:       drive(5'($urandom), 3'($urandom), a, b, $urandom & 32'hFFFF_FFFC, im);
        default: drive(TYPE_BRANCH, 3'($urandom), a, b, $urandom & 32'hFFFF_FFFC, im);
      endcase
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
